// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forward
// selects, shadow-stage record and the forwarding priority helper.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_FLUSH    = 2'b10,
    ST_MEM_WAIT = 2'b11
  } ctrl_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } stage_t;

  // The younger producer (MEM) wins over WB; x0 never forwards.
  function automatic logic [1:0] fwd_select(input stage_t mem_s, input stage_t wb_s,
                                            input logic [REG_ADDR_W-1:0] src);
    if (mem_s.valid && mem_s.reg_write && (mem_s.rd != '0) && (mem_s.rd == src))
      return FWD_MEM;
    else if (wb_s.valid && wb_s.reg_write && (wb_s.rd != '0) && (wb_s.rd == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow copies of the EX, MEM and WB stage control fields, advancing in
// lock-step with the real pipeline registers.
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   freeze,
  input  logic   bubble,
  input  stage_t id_stage,
  output stage_t ex_stage,
  output stage_t mem_stage,
  output stage_t wb_stage
);

  // NOTE: every shadow field is cleared on reset, not only valid, so that
  // stale register indices can never match a forwarding compare afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_stage  <= '0;
      mem_stage <= '0;
      wb_stage  <= '0;
    end else if (!freeze) begin
      // NOTE: non-blocking assignments make all three stages shift from their
      // pre-edge values; blocking here would collapse the pipeline in one edge.
      wb_stage  <= mem_stage;
      mem_stage <= ex_stage;
      ex_stage  <= bubble ? '0 : id_stage;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory freeze FSM
// and EX-stage operand forwarding selects.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [1:0]            ctrl_state
);

  ctrl_state_t state, state_nxt;
  logic        pend_branch, pend_branch_nxt;
  logic        pend_flush, pend_flush_nxt;
  stage_t      id_stage, ex_stage, mem_stage, wb_stage;
  logic        load_use;
  logic        stall_c, bubble_c, flush_c;

  assign id_stage = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write,
                      mem_read: id_mem_read, rs1: id_rs1, rs2: id_rs2};

  assign load_use = id_valid && ex_stage.valid && ex_stage.mem_read && (ex_stage.rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_stage.rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_stage.rd)));

  // A freeze can swallow a branch pulse or the second squash cycle; the
  // pend_* flags carry that work across MEM_WAIT so it runs on resume.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_nxt       = ST_RUN;
    pend_branch_nxt = 1'b0;
    pend_flush_nxt  = 1'b0;
    stall_c         = 1'b0;
    bubble_c        = 1'b0;
    flush_c         = 1'b0;
    if (mem_busy) begin
      stall_c         = 1'b1;
      state_nxt       = ST_MEM_WAIT;
      pend_branch_nxt = pend_branch | ex_branch_taken;
      pend_flush_nxt  = pend_flush | (state == ST_FLUSH);
    end else if (ex_branch_taken || pend_branch) begin
      flush_c   = 1'b1;
      bubble_c  = 1'b1;
      state_nxt = ST_FLUSH;
    end else if ((state == ST_FLUSH) || pend_flush) begin
      flush_c = 1'b1;
    end else if (((state == ST_RUN) || (state == ST_MEM_WAIT)) && load_use) begin
      stall_c   = 1'b1;
      bubble_c  = 1'b1;
      state_nxt = ST_LU_STALL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      pend_branch <= 1'b0;
      pend_flush  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend_branch <= pend_branch_nxt;
      pend_flush  <= pend_flush_nxt;
    end
  end

  hazard_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .freeze    (mem_busy),
    .bubble    (bubble_c | flush_c | ~id_valid),
    .id_stage  (id_stage),
    .ex_stage  (ex_stage),
    .mem_stage (mem_stage),
    .wb_stage  (wb_stage)
  );

  assign pc_stall     = stall_c & ~reset;
  assign if_id_stall  = stall_c & ~reset;
  assign id_ex_bubble = bubble_c & ~reset;
  assign if_id_flush  = flush_c & ~reset;
  assign fwd_a_sel    = fwd_select(mem_stage, wb_stage, ex_stage.rs1);
  assign fwd_b_sel    = fwd_select(mem_stage, wb_stage, ex_stage.rs2);
  assign ctrl_state   = state;

  logic unused_fields;
  assign unused_fields = ^{ex_stage.reg_write, mem_stage.mem_read, mem_stage.rs1,
                           mem_stage.rs2, wb_stage.mem_read, wb_stage.rs1, wb_stage.rs2};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: per-cycle vector table plus hand-written freeze/reset
// sequences, with expected outputs queued at drive time and popped at sample.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic       ex_branch_taken = 1'b0, mem_busy = 1'b0;
  logic       pc_stall, if_id_stall, id_ex_bubble, if_id_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel, ctrl_state;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .ctrl_state      (ctrl_state)
  );

  typedef struct packed {
    logic       pc, ifid, bub, flush;
    logic [1:0] fa, fb, st;
  } out_t;

  typedef struct packed {
    logic       iv;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, mr;
  } ins_t;

  typedef struct packed {
    logic rst;
    ins_t id;
    logic br, busy;
    out_t exp;
  } vec_t;

  localparam logic [1:0] RUN = 2'b00, LUS = 2'b01, FLS = 2'b10, MW = 2'b11;
  localparam ins_t NOP = '0;

  vec_t tbl[$];
  out_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic ins_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    return '{1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1};
  endfunction

  function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return '{1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0};
  endfunction

  function automatic out_t o(input logic pc, input logic bub, input logic fl,
                             input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] st);
    return '{pc, pc, bub, fl, fa, fb, st};
  endfunction

  task automatic row(input logic rst, input ins_t id, input logic br, input logic busy,
                     input out_t exp);
    tbl.push_back('{rst, id, br, busy, exp});
  endtask

  task automatic check(input string name, input out_t got, input out_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got pc=%b ifid=%b bub=%b flush=%b fa=%b fb=%b st=%b, want pc=%b ifid=%b bub=%b flush=%b fa=%b fb=%b st=%b",
               name, got.pc, got.ifid, got.bub, got.flush, got.fa, got.fb, got.st,
               want.pc, want.ifid, want.bub, want.flush, want.fa, want.fb, want.st);
    end
  endtask

  // One pipeline cycle: drive just after the rising edge, sample at the falling edge.
  task automatic step(input vec_t v, input string name);
    out_t got;
    @(posedge clk);
    #1;
    reset = v.rst;
    {id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_reg_write, id_mem_read} = v.id;
    ex_branch_taken = v.br;
    mem_busy        = v.busy;
    sb.push_back(v.exp);
    @(negedge clk);
    got = '{pc_stall, if_id_stall, id_ex_bubble, if_id_flush, fwd_a_sel, fwd_b_sel, ctrl_state};
    check(name, got, sb.pop_front());
  endtask

  initial begin
    // reset gates every output even with events present
    row(1, lw(5'd5, 5'd1), 1, 1, o(0, 0, 0, 2'b00, 2'b00, RUN));       // 0
    // load-use: lw x5 ; add x6,x5,x7
    row(0, lw(5'd5, 5'd1), 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN));       // 1
    row(0, alu(5'd6, 5'd5, 5'd7), 0, 0, o(1, 1, 0, 2'b00, 2'b00, RUN)); // 2
    row(0, alu(5'd6, 5'd5, 5'd7), 0, 0, o(0, 0, 0, 2'b00, 2'b00, LUS)); // 3
    row(0, NOP, 0, 0, o(0, 0, 0, 2'b01, 2'b00, RUN));                   // 4
    // add x3,x1,x2 ; sub x4,x3,x3
    row(0, alu(5'd3, 5'd1, 5'd2), 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN)); // 5
    row(0, alu(5'd4, 5'd3, 5'd3), 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN)); // 6
    row(0, NOP, 0, 0, o(0, 0, 0, 2'b10, 2'b10, RUN));                   // 7
    row(0, NOP, 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN));                   // 8
    // x0 as load destination, then read
    row(0, lw(5'd0, 5'd2), 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN));        // 9
    row(0, alu(5'd1, 5'd0, 5'd0), 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN)); // 10
    row(0, NOP, 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN));                   // 11
    row(0, NOP, 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN));                   // 12
    // single-cycle taken branch
    row(0, alu(5'd9, 5'd1, 5'd2), 1, 0, o(0, 1, 1, 2'b00, 2'b00, RUN)); // 13
    row(0, NOP, 0, 0, o(0, 0, 1, 2'b00, 2'b00, FLS));                   // 14
    row(0, NOP, 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN));                   // 15
    // branch coinciding with a load-use hazard: flush only
    row(0, lw(5'd8, 5'd1), 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN));        // 16
    row(0, alu(5'd10, 5'd8, 5'd0), 1, 0, o(0, 1, 1, 2'b00, 2'b00, RUN)); // 17
    row(0, NOP, 0, 0, o(0, 0, 1, 2'b00, 2'b00, FLS));                   // 18
    row(0, NOP, 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN));                   // 19
    // mem_busy for 3 cycles over a pending load-use stall
    row(0, lw(5'd5, 5'd1), 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN));        // 20
    row(0, alu(5'd6, 5'd5, 5'd7), 0, 1, o(1, 0, 0, 2'b00, 2'b00, RUN)); // 21
    row(0, alu(5'd6, 5'd5, 5'd7), 0, 1, o(1, 0, 0, 2'b00, 2'b00, MW));  // 22
    row(0, alu(5'd6, 5'd5, 5'd7), 0, 1, o(1, 0, 0, 2'b00, 2'b00, MW));  // 23
    row(0, alu(5'd6, 5'd5, 5'd7), 0, 0, o(1, 1, 0, 2'b00, 2'b00, MW));  // 24
    row(0, alu(5'd6, 5'd5, 5'd7), 0, 0, o(0, 0, 0, 2'b00, 2'b00, LUS)); // 25
    row(0, NOP, 0, 0, o(0, 0, 0, 2'b01, 2'b00, RUN));                   // 26
    // mem_busy arriving in FLUSH defers the second squash
    row(0, NOP, 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN));                   // 27
    row(0, alu(5'd1, 5'd2, 5'd3), 1, 0, o(0, 1, 1, 2'b00, 2'b00, RUN)); // 28
    row(0, NOP, 0, 1, o(1, 0, 0, 2'b00, 2'b00, FLS));                   // 29
    row(0, NOP, 0, 0, o(0, 0, 1, 2'b00, 2'b00, MW));                    // 30
    row(0, NOP, 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN));                   // 31
    // reset asserted in FLUSH
    row(0, NOP, 1, 0, o(0, 1, 1, 2'b00, 2'b00, RUN));                   // 32
    row(1, NOP, 1, 1, o(0, 0, 0, 2'b00, 2'b00, RUN));                   // 33
    row(0, NOP, 0, 0, o(0, 0, 0, 2'b00, 2'b00, RUN));                   // 34

    foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

    // Reset during MEM_WAIT abandons the deferred flush.
    step('{0, alu(5'd9, 5'd1, 5'd2), 1'b1, 1'b0, o(0, 1, 1, 2'b00, 2'b00, RUN)}, "rstmw_br");
    step('{0, NOP, 1'b0, 1'b1, o(1, 0, 0, 2'b00, 2'b00, FLS)}, "rstmw_busy1");
    step('{0, NOP, 1'b0, 1'b1, o(1, 0, 0, 2'b00, 2'b00, MW)}, "rstmw_busy2");
    step('{1, NOP, 1'b0, 1'b1, o(0, 0, 0, 2'b00, 2'b00, RUN)}, "rstmw_reset");
    step('{0, NOP, 1'b0, 1'b0, o(0, 0, 0, 2'b00, 2'b00, RUN)}, "rstmw_release");

    // A branch pulse swallowed by a freeze is replayed on resume.
    step('{0, NOP, 1'b1, 1'b1, o(1, 0, 0, 2'b00, 2'b00, RUN)}, "pendbr_busy");
    step('{0, NOP, 1'b0, 1'b0, o(0, 1, 1, 2'b00, 2'b00, MW)}, "pendbr_resume");
    step('{0, NOP, 1'b0, 1'b0, o(0, 0, 1, 2'b00, 2'b00, FLS)}, "pendbr_flush2");
    step('{0, NOP, 1'b0, 1'b0, o(0, 0, 0, 2'b00, 2'b00, RUN)}, "pendbr_run");

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
